// File: rtl/uprj_uart_tx_if.sv
// +----------------------------------------------------------------------+
// | uprj_uart_tx_if : ready/valid byte write channel into the UART FIFO  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

interface uprj_uart_tx_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );
endinterface

`default_nettype wire

// File: rtl/uprj_uart_tx.sv
// +----------------------------------------------------------------------+
// | uprj_uart_tx : FIFO-buffered UART transmitter, 8N1 LSB first         |
// | Optional macro UART_TX_PARITY_EN adds an even parity bit (8E1).      |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module uprj_uart_tx #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  uprj_uart_tx_if.slave               wr,
  input  logic [DIV_W-1:0]            cfg_div,
  input  logic                        cfg_en,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int               AW        = $clog2(FIFO_DEPTH);
  localparam int               PW        = AW + 1;
  localparam logic [PW-1:0]    C_DEPTH   = PW'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] C_MIN_DIV = DIV_W'(2);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t           state_q,    state_d;
  logic [PW-1:0]    wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q,   rd_ptr_d;
  logic             wr_ready_q, wr_ready_d;
  logic [7:0]       shift_q,    shift_d;
  logic [2:0]       bit_cnt_q,  bit_cnt_d;
  logic [DIV_W-1:0] baud_q,     baud_d;
  logic [DIV_W-1:0] div_q,      div_d;
  logic             tx_q,       tx_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_q,   parity_d;
`endif

  logic [7:0]       mem_q [FIFO_DEPTH];

  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_bit_end;
  logic [DIV_W-1:0] w_div_eff;
  logic [DIV_W-1:0] w_reload;
  logic [7:0]       w_head;
  logic [PW-1:0]    w_level;

  assign w_level   = wr_ptr_q - rd_ptr_q;
  assign w_empty   = (w_level == '0);
  assign w_push    = wr.wr_valid && wr_ready_q;
  assign w_bit_end = (baud_q == '0);
  assign w_div_eff = (cfg_div < C_MIN_DIV) ? C_MIN_DIV : cfg_div;
  assign w_reload  = div_q - DIV_W'(1);
  assign w_head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    baud_d    = baud_q;
    div_d     = div_q;
    w_pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    if (w_push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_en && !w_empty) begin
          w_pop = 1'b1;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          state_d = ST_DATA;
          baud_d  = w_reload;
        end else begin
          baud_d  = baud_q - DIV_W'(1);
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          baud_d    = w_reload;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          baud_d = baud_q - DIV_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) begin
          state_d = ST_STOP;
          baud_d  = w_reload;
        end else begin
          baud_d  = baud_q - DIV_W'(1);
        end
      end
`endif
      ST_STOP: begin
        // Chaining straight into the next START keeps frames gap-free.
        if (w_bit_end) begin
          if (cfg_en && !w_empty) begin
            w_pop = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q - DIV_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The divider is latched here so a cfg_div change never disturbs a frame in flight.
    if (w_pop) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      shift_d   = w_head;
      div_d     = w_div_eff;
      baud_d    = w_div_eff - DIV_W'(1);
      bit_cnt_d = 3'd0;
      state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
      parity_d  = ^w_head;
`endif
    end

    wr_ready_d = ((wr_ptr_d - rd_ptr_d) != C_DEPTH);

    // The line follows the current state one clock later, which gives the two-clock start latency.
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_q;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ready_q <= 1'b1;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      baud_q     <= '0;
      div_q      <= C_MIN_DIV;
      tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ready_q <= wr_ready_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_q     <= baud_d;
      div_q      <= div_d;
      tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr.wr_data;
    end
  end

  assign tx          = tx_q;
  assign busy        = (state_q != ST_IDLE) || !w_empty;
  assign fifo_level  = w_level;
  assign wr.wr_ready = wr_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_uprj_uart_tx.sv
// +----------------------------------------------------------------------+
// | tb_uprj_uart_tx : self-checking bench for uprj_uart_tx               |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uprj_uart_tx;

  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] cfg_div;
  logic        cfg_en;
  logic        tx;
  logic        busy;
  logic [3:0]  fifo_level;

  uprj_uart_tx_if wif ();

  uprj_uart_tx #(
    .FIFO_DEPTH (DEPTH),
    .DIV_W      (16)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .wr         (wif),
    .cfg_div    (cfg_div),
    .cfg_en     (cfg_en),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] fifo_m[$];
  logic [7:0] cur_b, nxt_b;
  int         cur_d, nxt_d;
  bit         have_nxt, nxt_gap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  // Serial bit idx of an 8N1/8E1 frame: start, data LSB first, [parity], stop.
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (NB == 11 && idx == 9) return logic'($countones(b) % 2);
    return 1'b1;
  endfunction

  // Walks one frame cycle by cycle; act 1=push arg, 2=set cfg_div, 3=drop cfg_en.
  task automatic run_frame(input int act_cyc, input int act, input int arg);
    int total, ac;
    bit acc, popnow, idlepop;
    total    = NB * cur_d;
    ac       = (act_cyc < -1) ? total + act_cyc : act_cyc;
    have_nxt = 0;
    for (int n = 0; n < total; n++) begin
      check("tx_bit", 32'(tx), 32'(exp_bit(cur_b, n / cur_d)));
      check("level", 32'(fifo_level), 32'(fifo_m.size()));
      check("wr_ready", 32'(wif.wr_ready), 32'(fifo_m.size() < DEPTH));
      if (n < total - 1)
        check("busy_frame", 32'(busy), 1);
      else
        check("busy_end", 32'(busy), 32'(have_nxt || fifo_m.size() > 0));
      if (n == ac) begin
        case (act)
          1: begin wif.wr_valid = 1'b1; wif.wr_data = arg[7:0]; end
          2: cfg_div = arg[15:0];
          3: cfg_en = 1'b0;
          default: ;
        endcase
      end
      acc     = wif.wr_valid && (fifo_m.size() < DEPTH);
      popnow  = (n == total - 2) && cfg_en && (fifo_m.size() > 0);
      idlepop = (n == total - 1) && !have_nxt && cfg_en && (fifo_m.size() > 0);
      tick();
      if (popnow || idlepop) begin
        nxt_b    = fifo_m.pop_front();
        nxt_d    = eff(int'(cfg_div));
        have_nxt = 1;
        nxt_gap  = idlepop;
      end
      if (acc) fifo_m.push_back(wif.wr_data);
      wif.wr_valid = 1'b0;
    end
  endtask

  task automatic idle_launch();
    check("launch_idle_tx", 32'(tx), 1);
    tick();
    cur_b = fifo_m.pop_front();
    cur_d = eff(int'(cfg_div));
    check("launch_lat_tx", 32'(tx), 1);
    check("launch_level", 32'(fifo_level), 32'(fifo_m.size()));
    tick();
  endtask

  task automatic step_next(input int act_cyc, input int act, input int arg);
    cur_b = nxt_b;
    cur_d = nxt_d;
    if (nxt_gap) begin
      check("gap_tx", 32'(tx), 1);
      tick();
    end
    run_frame(act_cyc, act, arg);
  endtask

  task automatic start_idle(input logic [7:0] b);
    wif.wr_valid = 1'b1;
    wif.wr_data  = b;
    tick();
    fifo_m.push_back(b);
    wif.wr_valid = 1'b0;
    check("push_level", 32'(fifo_level), 1);
    check("push_busy", 32'(busy), 1);
    idle_launch();
  endtask

  task automatic drain();
    while (have_nxt || (cfg_en && fifo_m.size() > 0)) begin
      if (have_nxt) begin
        step_next(-1, 0, 0);
      end else begin
        idle_launch();
        run_frame(-1, 0, 0);
      end
    end
    check("idle_tx", 32'(tx), 1);
    check("idle_busy", 32'(busy), 32'(fifo_m.size() > 0));
  endtask

  task automatic push_burst(input int cnt);
    bit acc;
    for (int i = 0; i < cnt; i++) begin
      wif.wr_valid = 1'b1;
      wif.wr_data  = 8'($urandom);
      acc = fifo_m.size() < DEPTH;
      tick();
      if (acc) fifo_m.push_back(wif.wr_data);
    end
    wif.wr_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; cfg_div = 16'd4; cfg_en = 1'b0;
    wif.wr_valid = 1'b0; wif.wr_data = 8'h00;
    have_nxt = 0; nxt_gap = 0; cur_b = 8'h00; nxt_b = 8'h00; cur_d = 2; nxt_d = 2;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    tick();
    check("rst_tx", 32'(tx), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_wr_ready", 32'(wif.wr_ready), 1);
    check("rst_level", 32'(fifo_level), 0);

    // 0x55 at div 4, then 0xA3 at div 0 (treated as 2)
    cfg_en = 1'b1; cfg_div = 16'd4;
    start_idle(8'h55); run_frame(-1, 0, 0); drain();
    cfg_div = 16'd0;
    start_idle(8'hA3); run_frame(-1, 0, 0); drain();

    // random bytes and dividers, with a random extra push landing anywhere in the frame
    for (int r = 0; r < 8; r++) begin
      cfg_div = 16'($urandom_range(0, 6));
      start_idle(8'($urandom));
      run_frame(int'($urandom_range(0, NB * cur_d - 1)), 1, int'($urandom_range(0, 255)));
      drain();
    end

    // fill while disabled, overflow push ignored, then back-to-back drain
    cfg_en = 1'b0; cfg_div = 16'd3;
    push_burst(9);
    check("fill_level", 32'(fifo_level), 8);
    check("fill_wr_ready", 32'(wif.wr_ready), 0);
    repeat (3) begin
      check("dis_tx", 32'(tx), 1);
      tick();
    end
    cfg_en = 1'b1;
    idle_launch();
    run_frame(NB * cur_d / 2, 1, 8'hC1);
    step_next(-2, 1, 8'hC2);
    step_next(-2, 1, 8'hC3);
    drain();

    // divider change mid-frame, then enable dropped mid-frame
    cfg_en = 1'b0; cfg_div = 16'd4;
    push_burst(3);
    cfg_en = 1'b1;
    idle_launch();
    run_frame(2 * cur_d, 2, 8);
    step_next(3 * nxt_d, 3, 0);
    repeat (6) begin
      check("en_off_tx", 32'(tx), 1);
      check("en_off_busy", 32'(busy), 1);
      check("en_off_level", 32'(fifo_level), 32'(fifo_m.size()));
      tick();
    end
    cfg_en = 1'b1;
    drain();

    // asynchronous reset mid-frame with a byte still queued
    cfg_div = 16'd3;
    start_idle(8'($urandom));
    wif.wr_valid = 1'b1; wif.wr_data = 8'h5A;
    tick();
    wif.wr_valid = 1'b0;
    repeat (4) tick();
    #2 resetn = 1'b0;
    #1;
    check("arst_tx", 32'(tx), 1);
    check("arst_busy", 32'(busy), 0);
    check("arst_level", 32'(fifo_level), 0);
    check("arst_wr_ready", 32'(wif.wr_ready), 1);
    fifo_m.delete();
    have_nxt = 0;
    tick();
    resetn = 1'b1;
    repeat (3) begin
      tick();
      check("post_rst_tx", 32'(tx), 1);
      check("post_rst_busy", 32'(busy), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
